// File: rtl/tape_ram_writer_if.sv
// Loader/arbiter side signals of the tape RAM writer: byte stream in, RAM write port and status out.
// master = loader + RAM arbiter side, slave = tape_ram_writer.
interface tape_ram_writer_if;
    logic        ioctl_download;
    logic [15:0] tape_addr;
    logic        tape_wr;
    logic [7:0]  tape_dout;
    logic        ram_slot;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic        busy;
    logic        overflow;
    logic        load_done;

    modport master (
        output ioctl_download, tape_addr, tape_wr, tape_dout, ram_slot,
        input  ram_addr, ram_dout, ram_we, busy, overflow, load_done
    );

    modport slave (
        input  ioctl_download, tape_addr, tape_wr, tape_dout, ram_slot,
        output ram_addr, ram_dout, ram_we, busy, overflow, load_done
    );
endinterface

// File: rtl/tape_ram_writer.sv
// Buffers TAP loader byte writes in a FIFO and commits them to RAM in arbiter-granted slots.
// Optional BASIC end-pointer patch after the load is enabled by defining TAPE_BASIC_PTR_EN.
module tape_ram_writer #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] PTR_ADDR   = 16'h009C
) (
    input logic             clk,
    input logic             reset_n,
    tape_ram_writer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    // state    | meaning
    // S_IDLE   | waiting for a download, tape_wr ignored
    // S_STREAM | accepting bytes, popping on ram_slot
    // S_DRAIN  | download ended, popping until FIFO empty
    // S_PTR_LO | write low byte of last_addr+1 to PTR_ADDR
    // S_PTR_HI | write high byte of last_addr+1 to PTR_ADDR+1
    // S_DONE   | one-cycle load_done
    typedef enum logic [2:0] {
        S_IDLE, S_STREAM, S_DRAIN, S_PTR_LO, S_PTR_HI, S_DONE
    } state_t;

    state_t              state_q;
    logic [23:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                have_data_q;
    logic [15:0]         last_addr_q;
    logic [15:0]         ram_addr_q;
    logic [7:0]          ram_dout_q;
    logic                ram_we_q;
    logic                busy_q;
    logic                overflow_q;
    logic                load_done_q;

    logic        fifo_empty, fifo_full;
    logic        pop, push_req, push;
    logic [15:0] ptr_val;
    logic [23:0] head;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                        (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    assign pop      = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && bus.ram_slot && !fifo_empty;
    assign push_req = (state_q == S_STREAM) && bus.tape_wr;
    assign push     = push_req && (!fifo_full || pop);
    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    assign ptr_val  = last_addr_q + 16'd1;
    assign head     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

`ifndef TAPE_BASIC_PTR_EN
    logic unused_ptr_cfg;
    assign unused_ptr_cfg = ^{PTR_ADDR, ptr_val, have_data_q};
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {bus.tape_addr, bus.tape_dout};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            have_data_q <= 1'b0;
            last_addr_q <= 16'h0000;
            ram_addr_q  <= 16'h0000;
            ram_dout_q  <= 8'h00;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            ram_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;

            if (pop) begin
                ram_we_q   <= 1'b1;
                ram_addr_q <= head[23:8];
                ram_dout_q <= head[7:0];
            end

            if (push) begin
                have_data_q <= 1'b1;
                last_addr_q <= bus.tape_addr;
            end else if (push_req) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.ioctl_download) begin
                        state_q     <= S_STREAM;
                        busy_q      <= 1'b1;
                        overflow_q  <= 1'b0;
                        have_data_q <= 1'b0;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                    end
                end
                S_STREAM: begin
                    if (!bus.ioctl_download) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
`ifdef TAPE_BASIC_PTR_EN
                        if (have_data_q) begin
                            state_q <= S_PTR_LO;
                        end else begin
                            state_q     <= S_DONE;
                            load_done_q <= 1'b1;
                        end
`else
                        state_q     <= S_DONE;
                        load_done_q <= 1'b1;
`endif
                    end
                end
`ifdef TAPE_BASIC_PTR_EN
                S_PTR_LO: begin
                    if (bus.ram_slot) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= PTR_ADDR;
                        ram_dout_q <= ptr_val[7:0];
                        state_q    <= S_PTR_HI;
                    end
                end
                S_PTR_HI: begin
                    if (bus.ram_slot) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= PTR_ADDR + 16'd1;
                        ram_dout_q  <= ptr_val[15:8];
                        state_q     <= S_DONE;
                        load_done_q <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.load_done = load_done_q;
endmodule

// File: doc/tape_ram_writer.md
# tape_ram_writer

Downstream stage of the TAP cassette loader in the Oric core. Accepts the loader's byte-write stream (`tape_addr`/`tape_wr`/`tape_dout`), buffers it in a small FIFO, and commits each byte to main RAM only in arbiter-granted slots, so that loading never collides with CPU or video RAM cycles. After the download ends and the FIFO drains, it optionally patches the BASIC end-of-program pointer, then pulses `load_done`.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries of {addr[15:0], data[7:0]}.
- `PTR_ADDR`, default 16'h009C: low byte of the BASIC end pointer; the high byte is at `PTR_ADDR+1`.

Ports:
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `ioctl_download` in 1: high while a TAP download is in progress.
- `tape_addr` in 16: target RAM address from the loader.
- `tape_wr` in 1: every cycle it is high carries one byte.
- `tape_dout` in 8: byte data.
- `ram_slot` in 1: one-cycle notice from the RAM arbiter that the cycle after this one is free for this block.
- `ram_addr` out 16: RAM write address.
- `ram_dout` out 8: RAM write data.
- `ram_we` out 1: RAM write strobe, one cycle wide.
- `busy` out 1: high in every state except IDLE.
- `overflow` out 1: sticky; set when a byte is dropped, cleared at the start of the next download.
- `load_done` out 1: one-cycle pulse when a load has been fully committed.

## Operation
States:
- **IDLE**
  - `ioctl_download`=1 → STREAM.
  - On entry to STREAM: clear `overflow`, clear `have_data`, empty the FIFO.
  - `tape_wr` is ignored in IDLE.
- **STREAM**
  - Push: `tape_wr`=1 pushes {`tape_addr`, `tape_dout`}, sets `have_data`, and latches `last_addr`=`tape_addr`.
  - Push acceptance: the push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Dropped bytes: otherwise the byte is dropped, `overflow` is set, and `last_addr` is unchanged.
  - `ioctl_download`=0 → DRAIN. A `tape_wr` arriving in that same cycle is still pushed.
- **DRAIN**
  - Pops continue. `tape_wr` is ignored.
  - FIFO empty → PTR_LO if `TAPE_BASIC_PTR_EN` is defined and `have_data`=1; otherwise → DONE.
  - `ioctl_download` rising in DRAIN is not honoured until IDLE. A new download's first bytes may be lost, and this is documented behaviour.
- **PTR_LO**
  - On `ram_slot`, write the low byte of (`last_addr`+1) to `PTR_ADDR` → PTR_HI.
- **PTR_HI**
  - On `ram_slot`, write the high byte of (`last_addr`+1) to `PTR_ADDR+1` → DONE.
- **DONE**
  - `load_done`=1 for this single cycle → IDLE.

Pop rule:
- In STREAM or DRAIN, `ram_slot`=1 with the FIFO non-empty pops the head.
- The popped entry is presented on the next cycle.

Arithmetic and widths:
- `last_addr`+1 is computed modulo 2^16, so 16'hFFFF+1 = 16'h0000.
- The FIFO read and write pointers are DEPTH_LOG2+1 bits, with a wrap bit used for full/empty detection.
- Occupancy is never exceeded. The FIFO holds exactly 2^DEPTH_LOG2 entries.

## Timing
Reset:
- `reset_n`=0 sampled on a clock edge gives state IDLE, an empty FIFO, `have_data`=0, `last_addr`=0.
- All outputs are 0 at reset: `ram_addr`, `ram_dout`, `ram_we`, `busy`, `overflow`, `load_done`.
- Reset mid-load discards FIFO contents without writing them.

Outputs:
- All outputs are registered.
- `ram_slot` high in cycle N causes `ram_we`=1 in cycle N+1 only, with `ram_addr`/`ram_dout` valid in the same cycle.
- `ram_addr`/`ram_dout` hold their last values when `ram_we`=0.

Latency:
- Minimum latency from a push to its RAM write: `tape_wr` at N, `ram_slot` at N+1, `ram_we` at N+2.
- A push at N is not visible to a pop decision made in cycle N.

Misc:
- `ram_slot` with no work pending (empty FIFO, or IDLE/DONE) produces no write.
- `busy` rises the cycle after `ioctl_download` is sampled high.
- `busy` falls the cycle after DONE.

## Configuration
- `TAPE_BASIC_PTR_EN` defined:
  - PTR_LO/PTR_HI are present.
  - After each non-empty load, the end+1 pointer is written to `PTR_ADDR`/`PTR_ADDR+1`, so BASIC programs are immediately listable/runnable.
- `TAPE_BASIC_PTR_EN` undefined:
  - DRAIN goes straight to DONE.
  - No RAM write other than FIFO contents ever occurs.
  - The `PTR_ADDR` parameter is unused.

## Test plan
- **Basic flow:** download high, 3 bytes AA/BB/CC at 0x0501..0x0503, `ram_slot` every 4th cycle, download low → 3 `ram_we` pulses in order at matching address/data, then (macro on) writes 0x04→0x009C, 0x05→0x009D, then `load_done` one cycle, `busy` 0.
- **Overflow:** DEPTH_LOG2=3, 10 consecutive `tape_wr` cycles with no `ram_slot` → first 8 committed once slots are given, `overflow`=1, `last_addr` = 8th address.
- **Full FIFO with simultaneous push and pop:** FIFO full, `tape_wr` and `ram_slot` in the same cycle → byte accepted, `overflow` stays 0, occupancy stays 8.
- **Empty download:** download pulse with no `tape_wr` → no `ram_we` at all, `load_done` pulses, pointer not written.
- **Reset mid-load:** reset asserted with 5 entries queued → no further `ram_we`, all outputs 0; a subsequent clean download behaves as the basic flow.
- **Address wrap:** last byte at 0xFFFF (macro on) → pointer writes 0x00 to 0x009C and 0x00 to 0x009D.
